// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch/execute PC sequencer.
// Imported by pc_sequencer and npc_select.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

  localparam int IMM16_LSB = 0;
  localparam int IMM16_W   = 16;
  localparam int TGT26_LSB = 0;
  localparam int TGT26_W   = 26;

  // Branch displacement is a word offset: sign-extend, then scale by 4.
  function automatic logic [31:0] branch_offset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_select.sv
// Redirect-target mux for a retiring instruction, with the
// misaligned-target trap folded in.
module npc_select
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0]        i_pc,
  input  logic [TGT26_W-1:0] i_tgt26,
  input  logic               i_branch_taken,
  input  logic               i_jump,
  input  logic               i_jump_reg,
  input  logic [31:0]        i_rs_value,
  output logic [31:0]        o_target,
  output logic               o_misaligned
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_tgt;

  assign w_pc4    = i_pc + 32'd4;
  assign w_br_tgt = w_pc4 +
    branch_offset(i_tgt26[IMM16_LSB +: IMM16_W]);
  assign w_j_tgt  = {w_pc4[31:28],
    i_tgt26[TGT26_LSB +: TGT26_W], 2'b00};

  // Sources may be asserted together; order sets precedence.
  always_comb begin
    w_tgt = w_pc4;
    priority case (1'b1)
      i_jump_reg:     w_tgt = i_rs_value;
      i_jump:         w_tgt = w_j_tgt;
      i_branch_taken: w_tgt = w_br_tgt;
      default:        w_tgt = w_pc4;
    endcase
  end

  assign o_misaligned = |w_tgt[1:0];
  assign o_target     = o_misaligned ? EXC_VECTOR : w_tgt;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: drives NPC into the pc register and
// owns the instruction-fetch handshake.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      PC,
  output logic [31:0]      NPC,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [31:0]      rs_value,
  input  logic             halt_req,
  output logic             halted,
  output logic             exc,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_next;
  logic [31:0]      r_instr;
  logic             r_instr_valid;
  logic [CNT_W-1:0] r_instret;
  logic [31:0]      w_target;
  logic             w_misaligned;
  logic             w_load;
  logic             w_retire;

  npc_select #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_select (
    .i_pc           (PC),
    .i_tgt26        (r_instr[TGT26_W-1:0]),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_jump_reg     (jump_reg),
    .i_rs_value     (rs_value),
    .o_target       (w_target),
    .o_misaligned   (w_misaligned)
  );

  always_comb begin
    w_next   = r_state;
    NPC      = PC;
    imem_req = 1'b0;
    halted   = 1'b0;
    exc      = 1'b0;
    w_load   = 1'b0;
    w_retire = 1'b0;
    unique case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_load = 1'b1;
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_retire = 1'b1;
          NPC      = w_target;
          exc      = w_misaligned;
          w_next   = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_instret     <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end else if (w_retire) begin
        r_instr_valid <= 1'b0;
      end
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign instret     = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a PC-level reference model
// and a local pc register closing the NPC -> PC loop.
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h0000_0180;

  typedef struct {
    bit          is_exec;
    logic [31:0] a;
    logic        exc;
    logic [31:0] iw;
    logic [31:0] cnt;
  } item_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC, NPC, imem_rdata, instr, rs_value, instret;
  logic        imem_req, imem_ready, instr_valid, exec_done;
  logic        branch_taken, jump, jump_reg, halt_req;
  logic        halted, exc;

  int checks   = 0;
  int failures = 0;

  item_t       sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset)
    if (!Reset) PC <= 32'd0;
    else        PC <= NPC;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PC           (PC),
    .NPC          (NPC),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .rs_value     (rs_value),
    .halt_req     (halt_req),
    .halted       (halted),
    .exc          (exc),
    .instret      (instret)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Architectural next-PC rule, written as plain arithmetic.
  function automatic logic [31:0] ref_target(
    input logic [31:0] pc, input logic [31:0] iw,
    input bit br, input bit j, input bit jr,
    input logic [31:0] rs);
    logic [31:0]        seq;
    logic signed [31:0] off;
    seq = pc + 32'd4;
    off = 32'($signed(iw[15:0]));
    if (jr) return rs;
    if (j)  return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
    if (br) return seq + off * 4;
    return seq;
  endfunction

  task automatic noise();
    exec_done    = 1'($urandom);
    branch_taken = 1'($urandom);
    jump         = 1'($urandom);
    jump_reg     = 1'($urandom);
    halt_req     = 1'($urandom);
    rs_value     = $urandom;
  endtask

  task automatic quiet();
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    jump_reg     = 1'b0;
    halt_req     = 1'b0;
    imem_ready   = 1'b0;
  endtask

  task automatic reset_assert();
    Reset = 1'b0;
    quiet();
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_exc", exc, 0);
    chk("rst_instret", instret, 0);
    sb.delete();
    m_pc  = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic reset_release();
    @(posedge Clk); #1;
    Reset = 1'b1;
    chk("idle_req", imem_req, 0);
    @(posedge Clk); #1;
    chk("fetch_req", imem_req, 1);
  endtask

  task automatic run_instr(input logic [31:0] iw,
                           input int rdly, input int edly,
                           input bit br, input bit j, input bit jr,
                           input bit hlt, input logic [31:0] rs);
    logic [31:0] t, e;
    bit          mis;
    int          n;
    item_t       it;
    t   = ref_target(m_pc, iw, br, j, jr, rs);
    mis = (t % 4) != 0;
    e   = mis ? EXC : t;
    it = '{is_exec: 1'b0, a: m_pc, exc: 1'b0, iw: 32'd0, cnt: 32'd0};
    sb.push_back(it);
    it = '{is_exec: 1'b1, a: e, exc: mis, iw: iw, cnt: m_cnt};
    sb.push_back(it);
    n = 0;
    imem_ready = 1'b0;
    while (!imem_req && n < 4) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!imem_req) begin
      flag_fail("fetch_timeout");
      sb.delete();
      return;
    end
    repeat (rdly) begin
      imem_ready = 1'b0;
      noise();
      @(posedge Clk); #1;
      chk("wait_req", imem_req, 1);
    end
    imem_ready = 1'b1;
    imem_rdata = iw;
    noise();
    @(posedge Clk); #1;
    chk("req_drop", imem_req, 0);
    imem_rdata = $urandom;
    repeat (edly) begin
      quiet();
      imem_ready   = 1'($urandom);
      branch_taken = 1'($urandom);
      jump_reg     = 1'($urandom);
      halt_req     = 1'($urandom);
      rs_value     = $urandom;
      @(posedge Clk); #1;
    end
    imem_ready   = 1'b0;
    exec_done    = 1'b1;
    branch_taken = br;
    jump         = j;
    jump_reg     = jr;
    halt_req     = hlt;
    rs_value     = rs;
    @(posedge Clk); #1;
    quiet();
    m_pc  = e;
    m_cnt = m_cnt + 1;
  endtask

  // Monitor: pops an expectation at every fetch handshake and retire.
  initial begin
    item_t it;
    forever begin
      @(negedge Clk);
      if (Reset === 1'b1) begin
        if (instr_valid && exec_done) begin
          if (sb.size() == 0 || !sb[0].is_exec) begin
            flag_fail("exec_order");
          end else begin
            it = sb.pop_front();
            chk("exec_npc", NPC, it.a);
            chk("exec_exc", exc, it.exc);
            chk("exec_instr", instr, it.iw);
            chk("exec_instret", instret, it.cnt);
          end
        end else begin
          chk("npc_hold", NPC, PC);
          chk("exc_quiet", exc, 0);
        end
        if (imem_req && imem_ready) begin
          if (sb.size() == 0 || sb[0].is_exec) begin
            flag_fail("fetch_order");
          end else begin
            it = sb.pop_front();
            chk("fetch_addr", PC, it.a);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] iw, rs;
    bit          br, j, jr;
    imem_rdata = 32'd0;
    rs_value   = 32'd0;
    reset_assert();
    reset_release();

    run_instr(32'h0000_0000, 0, 1, 0, 0, 0, 0, 32'd0);
    chk("instret_one", instret, 1);
    run_instr(32'h1234_5678, 5, 0, 0, 0, 0, 0, 32'd0);
    run_instr(32'h0, 0, 0, 0, 0, 1, 0, 32'h0000_0100);
    run_instr(32'h1000_FFFE, 1, 2, 1, 0, 0, 0, 32'd0);
    chk("branch_back", PC, 32'h0000_00FC);
    run_instr(32'h0, 0, 0, 0, 0, 1, 0, 32'h0000_0100);
    run_instr(32'h0800_0040, 2, 0, 1, 1, 0, 0, 32'd0);
    chk("jump_wins", PC, 32'h0000_0100);
    run_instr(32'h0, 0, 1, 0, 0, 1, 0, 32'h0000_2002);
    chk("exc_vec", PC, EXC);
    run_instr(32'h0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    run_instr(32'h0, 0, 0, 0, 0, 0, 0, 32'd0);
    chk("wrap_zero", PC, 32'd0);

    for (int k = 0; k < 150; k++) begin
      iw = $urandom;
      br = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 3) == 0);
      jr = ($urandom_range(0, 5) == 0);
      rs = $urandom;
      run_instr(iw, $urandom_range(0, 3), $urandom_range(0, 3),
                br, j, jr, 0, rs);
    end

    run_instr(32'h0, 0, 0, 0, 0, 1, 0, 32'h0000_0008);
    run_instr(32'hDEAD_BEEF, 1, 1, 0, 0, 0, 1, 32'd0);
    chk("halt_npc_pc", PC, 32'h0000_000C);
    repeat (20) begin
      noise();
      imem_ready = 1'($urandom);
      @(posedge Clk); #1;
      chk("halted", halted, 1);
      chk("halt_req_low", imem_req, 0);
      chk("halt_pc", PC, m_pc);
    end
    chk("halt_instret", instret, m_cnt);

    reset_assert();
    reset_release();
    @(posedge Clk); #1;
    chk("fetch_pending", imem_req, 1);
    #3;
    reset_assert();
    reset_release();
    run_instr(32'h0000_0000, 0, 1, 0, 0, 0, 0, 32'd0);
    chk("restart_pc", PC, 32'h0000_0004);
    chk("restart_cnt", instret, 1);

    @(posedge Clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/execute sequencer that drives the NPC input of the program counter register and owns the instruction-fetch handshake to instruction memory.
- Holds the PC steady while a fetch or an instruction is in flight.
- Selects the next PC from sequential, branch, jump and register-jump sources.
- Traps misaligned targets to an exception vector and supports halt.
- Sits between the pc register, instruction memory and the control/execute datapath of the multi-cycle simple CPU.

Parameters:
EXC_VECTOR, 32'h0000_0180, next PC when a redirect target is misaligned (bits[1:0] != 0)
CNT_W, 32, width of the retired-instruction counter

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
PC  input  32  current value from the pc register
NPC  output  32  next PC, fed to the pc register every cycle
imem_req  output  1  fetch request; instruction address is PC
imem_ready  input  1  instruction memory has valid data this cycle
imem_rdata  input  32  instruction word
instr  output  32  latched instruction to the decoder
instr_valid  output  1  instr is valid and executing
exec_done  input  1  datapath finished the current instruction this cycle
branch_taken  input  1  conditional branch resolved taken (sampled with exec_done)
jump  input  1  J/JAL (sampled with exec_done)
jump_reg  input  1  JR/JALR (sampled with exec_done)
rs_value  input  32  register target for jump_reg
halt_req  input  1  stop after the current instruction (sampled with exec_done)
halted  output  1  sequencer halted
exc  output  1  misaligned-target exception pulse, one cycle
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, Reset=0): state=IDLE; imem_req=0, instr=0, instr_valid=0, halted=0, exc=0, instret=0. NPC is combinational and equals PC in IDLE, so the pc register holds its reset value.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: unconditional transition to FETCH on the next edge. Gives exactly one dead cycle after reset release.
- FETCH: imem_req=1, NPC=PC.
  - On imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - Otherwise stay in FETCH with no limit on wait cycles.
  - imem_req deasserts in the cycle after ready is sampled.
- EXEC: imem_req=0, instr_valid=1.
  - While exec_done=0: NPC=PC.
  - On exec_done=1, NPC is chosen combinationally in the same cycle, so the pc register loads it on that edge.
  - Target priority: jump_reg, then jump, then branch_taken, then sequential.
    - jump_reg target: rs_value.
    - jump target: {PC+4[31:28], instr[25:0], 2'b00}.
    - branch target: PC+4 + (sign-extended instr[15:0] << 2).
    - sequential target: PC+4.
  - All arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
  - Misaligned chosen target (bits[1:0] != 0, possible only via jump_reg): NPC=EXC_VECTOR and exc=1 for that one cycle.
  - instret increments by 1 on every exec_done, including the exception case. It wraps at 2^CNT_W.
  - Next state: HALT if halt_req=1, else FETCH. instr_valid<=0 on that edge.
  - halt_req together with a redirect: the redirect NPC is still applied, then the sequencer halts.
- HALT: halted=1, NPC=PC, imem_req=0. Exits only through Reset.
- exec_done, imem_ready and the redirect inputs are ignored in any state where they are not listed.
- Reset asserted mid-fetch or mid-exec: everything returns to reset values immediately, and any outstanding fetch is abandoned.

Decomposition:
- Shared package: state encoding constants (IDLE, FETCH, EXEC, HALT), EXC_VECTOR default, instruction field slice positions (imm16, target26).
- One natural sub-module, npc_select: the purely combinational target mux, branch adder and alignment check. The FSM, instruction latch and counter stay in pc_sequencer.

Test Plan:
- Reset release, PC=0, imem_ready held high: IDLE for 1 cycle, imem_req=1 in cycle 2, instr_valid in cycle 3; exec_done in cycle 4 gives NPC=0x4 and instret=1.
- imem_ready delayed 5 cycles: NPC=PC and imem_req=1 held for all 5 cycles; instr latched only on the ready cycle.
- PC=0x100, instr imm16=0xFFFE, branch_taken with exec_done: NPC=0xFC. Same instr with jump and branch_taken both set, instr[25:0]=0x40: NPC=0x100 (jump wins).
- jump_reg with rs_value=0x2002: NPC=0x180 and exc pulse for exactly 1 cycle; instret still increments.
- halt_req with exec_done at PC=0x8: NPC=0xC, then halted=1 and imem_req stays 0 for 20 cycles; Reset pulse restores IDLE.
- Reset asserted while in FETCH with imem_req=1: imem_req=0 and instr_valid=0 asynchronously; after release the sequence restarts as in the first scenario.
